// File: rtl/pc_pkg.sv
// Shared constants and types for the instruction-fetch program counter.
package pc_pkg;

  localparam int PC_WIDTH      = 32;
  localparam int PC_STEP       = 4;
  localparam int PC_ALIGN_BITS = 2;

  typedef logic [PC_WIDTH-1:0] pc_addr_t;

  localparam pc_addr_t PC_RESET_VECTOR = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc_incrementer.sv
// Combinational sequential-fetch adder: y = a + STEP, modulo 2^WIDTH.
// One instance feeds both the link-address output and the register update.
module pc_incrementer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // Carry out of the top bit is dropped on purpose so the PC wraps to zero.
  assign y = a + WIDTH'(STEP);

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// Fetch-stage program counter: holds on stall, loads a redirect target, or
// advances by STEP. Redirect targets with nonzero low ALIGN_BITS are loaded
// unchanged and flagged through the registered misalign output.
// ALIGN_BITS must be at least 1.
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter int               STEP         = PC_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int               ALIGN_BITS   = PC_ALIGN_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             misalign
);

  logic [WIDTH-1:0] count_d;
  logic             misalign_d;

  pc_incrementer #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_incr (
    .a (count),
    .y (count_next)
  );

  // Priority select: stall holds everything, redirect beats sequential advance.
  always_comb begin
    count_d    = count;
    misalign_d = misalign;
    if (en) begin
      if (load) begin
        count_d    = in;
        misalign_d = |in[ALIGN_BITS-1:0];
      end else begin
        count_d    = count_next;
        misalign_d = 1'b0;
      end
    end
  end

  // PC and fault flag registers; reset is asynchronous and active low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= RESET_VECTOR;
      misalign <= 1'b0;
    end else begin
      count    <= count_d;
      misalign <= misalign_d;
    end
  end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, sequential fetch, stall,
// redirect with alignment flag, wrap-around and reset during a redirect.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        en;
  logic        load;
  logic [31:0] in;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        misalign;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  program_counter dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .in         (in),
    .count      (count),
    .count_next (count_next),
    .misalign   (misalign)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic l, input logic [31:0] d);
    en   = e;
    load = l;
    in   = d;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0);

    // Reset held across the first edge.
    #10;
    check("rst_count", count, 32'h0);
    check("rst_next", count_next, 32'h4);
    check("rst_misalign", {31'b0, misalign}, 32'h0);

    // Release and advance sequentially.
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    tick(); check("seq_1", count, 32'h4);
    tick(); check("seq_2", count, 32'h8);
    tick(); check("seq_3", count, 32'hC);
    tick(); check("seq_4", count, 32'h10);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_count", count, 32'h0);
    check("async_rst_next", count_next, 32'h4);
    tick(); check("rst_hold_edge", count, 32'h0);
    reset = 1'b1;
    tick(); check("post_rst_1", count, 32'h4);
    tick(); check("post_rst_2", count, 32'h8);

    // Stall with a pending redirect that must be ignored.
    drive(1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall", count, 32'h8);
    end
    drive(1'b1, 1'b0, 32'h100);
    tick(); check("resume", count, 32'hC);

    // Redirects, aligned then unaligned.
    drive(1'b1, 1'b1, 32'h40);
    tick(); check("redir_40", count, 32'h40);
    check("redir_40_mis", {31'b0, misalign}, 32'h0);
    drive(1'b1, 1'b1, 32'h42);
    tick(); check("redir_42", count, 32'h42);
    check("redir_42_mis", {31'b0, misalign}, 32'h1);
    drive(1'b0, 1'b0, 32'h0);
    tick(); check("stall_mis_hold", {31'b0, misalign}, 32'h1);
    check("stall_cnt_hold", count, 32'h42);
    drive(1'b1, 1'b0, 32'h0);
    tick(); check("seq_46", count, 32'h46);
    check("seq_46_mis", {31'b0, misalign}, 32'h0);

    // Wrap-around at the top of the address space.
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    tick(); check("wrap_load", count, 32'hFFFF_FFF8);
    drive(1'b1, 1'b0, 32'h0);
    tick(); check("wrap_fffc", count, 32'hFFFF_FFFC);
    check("wrap_next", count_next, 32'h0);
    tick(); check("wrap_zero", count, 32'h0);
    check("wrap_mis", {31'b0, misalign}, 32'h0);
    check("wrap_next_4", count_next, 32'h4);

    // Redirect to the current address reloads the same value.
    drive(1'b1, 1'b1, 32'h0);
    tick(); check("self_redir", count, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    tick(); check("pre_mixed", count, 32'h4);

    // Short reset pulse during an active redirect.
    drive(1'b1, 1'b1, 32'h200);
    #2;
    reset = 1'b0;
    #1;
    check("mixed_rst", count, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("mixed_rst_release", count, 32'h0);
    tick(); check("mixed_load", count, 32'h200);
    check("mixed_mis", {31'b0, misalign}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_program_counter

// File: doc/program_counter.md
Name: program_counter

Overview:
- 32-bit program counter register for the instruction-fetch stage.
- Each cycle it either holds (stall), loads a redirect target from `in` (branch/jump), or advances by STEP.
- `count` drives the instruction-memory address.
- It also provides `count_next` (count+STEP) as the link/return address and an alignment-fault flag for redirect targets.

Parameters:
- WIDTH, 32, address width of `count`, `in`, `count_next`.
- STEP, 4, byte increment per sequential fetch.
- RESET_VECTOR, 0, value of `count` during and after reset.
- ALIGN_BITS, 2, number of LSBs that must be zero in a legal target.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  advance enable; 0 = stall (hold count).
- load  input  1  redirect request; when en=1, count <= in.
- in  input  WIDTH  redirect target address.
- count  output  WIDTH  current PC, registered.
- count_next  output  WIDTH  count+STEP, combinational, modulo 2^WIDTH.
- misalign  output  1  registered; set when an accepted redirect target had nonzero low ALIGN_BITS.

Behaviour:
- Reset:
  - reset=0 immediately forces count=RESET_VECTOR and misalign=0, independent of clk.
  - Both hold while reset=0.
  - count_next follows as RESET_VECTOR+STEP.
- Release: first rising clk edge with reset=1 applies the normal update rule; no extra latency cycle.
- Update rule at rising clk when reset=1, in priority order:
  - en=0: count and misalign hold; load and in are ignored.
  - en=1, load=1: count <= in.
    - misalign <= 1 if in[ALIGN_BITS-1:0] != 0, else 0.
    - The unaligned value is still loaded unmodified; the fault is only flagged.
  - en=1, load=0: count <= count+STEP; misalign <= 0.
- Latency: one cycle from redirect/advance to new `count`. No combinational path from `in` to `count`.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Wrap-around: count=0xFFFFFFFC advances to 0x00000000 with no flag.
- Simultaneous events:
  - reset=0 overrides en/load.
  - load overrides sequential increment.
  - Redirect to the current address is legal and reloads the same value.
- Reset asserted mid-stall or mid-redirect: the pending operation is discarded; count=RESET_VECTOR.
- No X propagation: with reset released, count always holds a known value.

Decomposition:
- Shared package pc_pkg:
  - PC_WIDTH=32, PC_STEP=4, PC_RESET_VECTOR=32'h0000_0000, PC_ALIGN_BITS=2.
  - Typedef pc_addr_t as logic [PC_WIDTH-1:0].
- One natural sub-module: pc_incrementer.
  - Combinational count+STEP adder.
  - Shared by the count_next output and the sequential update path.
- Register and priority mux stay in program_counter.

Test Plan:
- Reset: hold reset=0 for 10 ns, en=0 -> count=0, count_next=4, misalign=0. Assert reset=0 asynchronously between edges -> count returns to 0 before the next edge.
- Sequential: release reset, en=1, load=0 for 4 edges -> count steps 4, 8, 12, 16.
- Stall: at count=8, en=0 for 3 edges with load=1, in=0x100 -> count stays 8. Re-enable with load=0 -> count=12.
- Redirect: en=1, load=1, in=0x0000_0040 -> count=0x40 next edge, misalign=0. Then in=0x0000_0042 -> count=0x42, misalign=1. Next sequential cycle -> count=0x46, misalign=0.
- Wrap: redirect to 0xFFFF_FFF8, then advance twice -> 0xFFFF_FFFC, then 0x0000_0000; count_next=0x0000_0000 while count=0xFFFF_FFFC.
- Mixed: reset pulse low for 3 ns during an active redirect (load=1, in=0x200) -> count=0, no load applied. After release the first edge loads 0x200 if load is still 1.
